// File: rtl/keypad_pkg.sv
// keypad_pkg: FSM states, column-drive constants and key encoding for hex_keypad_scanner.
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_e;
  localparam logic [3:0] COL_RESET = 4'b1110;
  localparam logic [3:0] ROW_NONE = 4'hF;
  function automatic logic [3:0] col_drive(input logic [1:0] c);
    return ~(4'b0001 << c);
  endfunction
  // Lowest row index wins when several rows are low.
  function automatic logic [1:0] low_row(input logic [3:0] row);
    return !row[0] ? 2'd0 : !row[1] ? 2'd1 : !row[2] ? 2'd2 : 2'd3;
  endfunction
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: parameterized-width two-flop synchronizer with a selectable reset value.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_rst_val,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= i_rst_val;
      sync_q <= i_rst_val;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end
  assign o_q = sync_q;
endmodule

// File: rtl/hex_keypad_scanner.sv
// hex_keypad_scanner: 4x4 matrix keypad scanner with press/release debounce and hex key output.
// KEYPAD_ENTRY_SHIFT_EN builds the 32-bit entry shift register; otherwise o_entry is tied to zero.
module hex_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_row,
  output logic [3:0]  o_col,
  output logic [3:0]  o_key,
  output logic        o_key_valid,
  output logic        o_pressed,
  output logic [31:0] o_entry
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST = BW'(DEBOUNCE_CYCLES - 1);
  state_e state_q, state_d;
  logic [1:0] col_q, col_d, row_q, row_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] deb_q, deb_d;
  logic [3:0] col_drv_q, key_q, key_d, row_s;
  logic valid_q, valid_d, pressed_q, pressed_d, row_low;
  sync_2ff #(.W(4)) u_row_sync (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_rst_val(ROW_NONE),
    .i_d      (i_row),
    .o_q      (row_s)
  );
  assign row_low = !row_s[row_q];
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    div_d     = div_q;
    deb_d     = deb_q;
    key_d     = key_q;
    valid_d   = 1'b0;
    pressed_d = pressed_q;
    unique case (state_q)
      SCAN: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (row_s != ROW_NONE) begin
            row_d   = low_row(row_s);
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (!row_low) begin
          state_d = SCAN;
          col_d   = col_q + 1'b1;
        end else if (deb_q == DEB_LAST) begin
          key_d     = key_code(row_q, col_q);
          valid_d   = 1'b1;
          pressed_d = 1'b1;
          state_d   = HELD;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      HELD: begin
        if (!row_low) begin
          deb_d   = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (row_low) begin
          deb_d   = '0;
          state_d = HELD;
        end else if (deb_q == DEB_LAST) begin
          pressed_d = 1'b0;
          col_d     = '0;
          state_d   = SCAN;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      default: state_d = SCAN;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= SCAN;
      col_q     <= '0;
      row_q     <= '0;
      div_q     <= '0;
      deb_q     <= '0;
      col_drv_q <= COL_RESET;
      key_q     <= '0;
      valid_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      div_q     <= div_d;
      deb_q     <= deb_d;
      col_drv_q <= col_drive(col_d);
      key_q     <= key_d;
      valid_q   <= valid_d;
      pressed_q <= pressed_d;
    end
  end
`ifdef KEYPAD_ENTRY_SHIFT_EN
  logic [31:0] entry_q;
  always_ff @(posedge i_clk) begin
    if (i_reset) entry_q <= '0;
    else if (valid_d) entry_q <= {entry_q[27:0], key_d};
  end
  assign o_entry = entry_q;
`else
  assign o_entry = '0;
`endif
  assign o_col       = col_drv_q;
  assign o_key       = key_q;
  assign o_key_valid = valid_q;
  assign o_pressed   = pressed_q;
endmodule

// File: tb/tb_hex_keypad_scanner.sv
// tb_hex_keypad_scanner: scoreboard bench driving a behavioural 4x4 keypad into hex_keypad_scanner.
module tb_hex_keypad_scanner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] row, col, key;
  logic key_valid, pressed;
  logic [31:0] entry;
  logic [15:0] down = '0;
  logic [3:0] exp_q[$];
  logic [3:0] popped;
  logic [31:0] exp_entry = '0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
`ifdef KEYPAD_ENTRY_SHIFT_EN
  localparam logic [31:0] ENTRY_6 = 32'h0000_0006, ENTRY_6A = 32'h0000_006A;
`else
  localparam logic [31:0] ENTRY_6 = 32'h0, ENTRY_6A = 32'h0;
`endif
  always #5 clk = ~clk;
  hex_keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_row      (row),
    .o_col      (col),
    .o_key      (key),
    .o_key_valid(key_valid),
    .o_pressed  (pressed),
    .o_entry    (entry)
  );
  // A pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (down[4*r+c] && col[c] == 1'b0) row[r] = 1'b0;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] col_of(input int c);
    logic [3:0] v;
    v = 4'b0001 << c;
    return ~v;
  endfunction
  always @(negedge clk) begin
    if (rst) exp_entry = '0;
    else if (key_valid) begin
      pulses++;
      check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        popped = exp_q.pop_front();
`ifdef KEYPAD_ENTRY_SHIFT_EN
        exp_entry = {exp_entry[27:0], popped};
`endif
        check("sb_key", key, popped);
        check("sb_entry", entry, exp_entry);
        check("sb_pressed", pressed, 1);
      end
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_col", col, 4'b1110);
    check("rst_key", key, 0);
    check("rst_valid", key_valid, 0);
    check("rst_pressed", pressed, 0);
    check("rst_entry", entry, 0);
    rst = 1'b0;
  endtask
  task automatic wait_col(input logic [3:0] c);
    int n = 0;
    while (col !== c && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("wait_col", col, c);
  endtask
  task automatic wait_valid(output int k);
    k = 0;
    while (key_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("valid_seen", key_valid, 1);
  endtask
  task automatic wait_release(output int k);
    k = 0;
    while (pressed !== 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("release_seen", pressed, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int k, p0;
    do_reset();
    for (int i = 0; i <= 16; i++) begin
      check("col_walk", col, col_of((i / 4) % 4));
      @(negedge clk);
    end
    // Clean press of key 6 aligned to the start of column 2.
    wait_col(4'b1101);
    wait_col(4'b1011);
    p0 = pulses;
    down[6] = 1'b1;
    exp_q.push_back(4'h6);
    wait_valid(k);
    check("press_latency", 32'(k), 32'd12);
    repeat (38) @(negedge clk);
    check("clean_one_pulse", 32'(pulses - p0), 32'd1);
    check("clean_key", key, 4'h6);
    check("clean_entry", entry, ENTRY_6);
    check("clean_pressed", pressed, 1);
    down[6] = 1'b0;
    wait_release(k);
    check("release_latency", 32'(k), 32'd11);
    check("col_after_release", col, 4'b1110);
    // Bounce: press dropped a few cycles into debounce.
    p0 = pulses;
    wait_col(4'b1101);
    wait_col(4'b1011);
    down[6] = 1'b1;
    repeat (6) @(negedge clk);
    check("bounce_frozen", col, 4'b1011);
    down[6] = 1'b0;
    k = 0;
    while (col == 4'b1011 && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("bounce_resume_col", col, 4'b0111);
    check("bounce_no_pulse", 32'(pulses - p0), 32'd0);
    // Long hold then a second key.
    do_reset();
    p0 = pulses;
    down[6] = 1'b1;
    exp_q.push_back(4'h6);
    wait_valid(k);
    repeat (200) @(negedge clk);
    check("hold_one_pulse", 32'(pulses - p0), 32'd1);
    down[6] = 1'b0;
    wait_release(k);
    down[10] = 1'b1;
    exp_q.push_back(4'hA);
    wait_valid(k);
    check("repeat_key", key, 4'hA);
    check("repeat_entry", entry, ENTRY_6A);
    @(negedge clk);
    check("repeat_two_pulses", 32'(pulses - p0), 32'd2);
    down[10] = 1'b0;
    wait_release(k);
    // Two rows low on column 1.
    down[1] = 1'b1;
    down[13] = 1'b1;
    exp_q.push_back(4'h1);
    wait_valid(k);
    check("multirow_key", key, 4'h1);
    down[1] = 1'b0;
    down[13] = 1'b0;
    wait_release(k);
    // Reset during the fourth debounce cycle.
    p0 = pulses;
    wait_col(4'b1101);
    wait_col(4'b1011);
    down[6] = 1'b1;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_col", col, 4'b1110);
    check("midrst_key", key, 0);
    check("midrst_valid", key_valid, 0);
    check("midrst_pressed", pressed, 0);
    check("midrst_entry", entry, 0);
    rst = 1'b0;
    down[6] = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_pulse", 32'(pulses - p0), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
